uart_rx_multi: RTL



---
 rtl/uart_rx_multi.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_rx_multi.sv
// Oversampling UART receiver: 2-flop synchroniser, start-glitch rejection, 3-sample majority
// per bit, optional parity, 1-2 stop bits, valid/ready output with parity/framing/overrun flags.
module uart_rx_multi #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 500000,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);
  localparam int BIT_CYCLES = (CLK_FREQ + BAUD/2) / BAUD;
  localparam int CW         = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CYCLES/2 - 1);
  localparam logic [CW-1:0] HALF    = CW'(BIT_CYCLES/2);
  localparam logic [CW-1:0] HALF_P1 = CW'(BIT_CYCLES/2 + 1);
  localparam logic [CW-1:0] LAST    = CW'(BIT_CYCLES - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT} state_t;

  state_t               state, state_n;
  logic                 rx_meta, rxs;
  logic                 s_a, s_b, maj;
  logic [CW-1:0]        ctr;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_l, frm_l;
  logic                 bit_state, decide, commit;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Third vote is the live sample taken at the decision cycle itself.
  assign maj       = (s_a & s_b) | (s_a & rxs) | (s_b & rxs);
  assign bit_state = (state == S_START) || (state == S_DATA) ||
                     (state == S_PAR)   || (state == S_STOP);
  assign decide    = bit_state && (ctr == HALF_P1);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    commit  = 1'b0;
    case (state)
      S_IDLE:  if (!rxs) state_n = S_START;
      S_START: if (decide) state_n = maj ? S_IDLE : S_DATA;
      S_DATA:  if (decide && bit_cnt == LAST_DATA) state_n = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (decide) state_n = S_STOP;
      S_STOP:  if (decide && bit_cnt == LAST_STOP) begin
                 commit  = 1'b1;
                 state_n = maj ? S_IDLE : S_WAIT;
               end
      S_WAIT:  if (rxs) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr     <= '0;
      bit_cnt <= '0;
      s_a     <= 1'b1;
      s_b     <= 1'b1;
      shreg   <= '0;
      par_l   <= 1'b0;
      frm_l   <= 1'b0;
    end else begin
      if (!bit_state || state_n == S_IDLE || state_n == S_WAIT) ctr <= '0;
      else if (ctr == LAST)                                     ctr <= '0;
      else                                                      ctr <= ctr + 1'b1;

      // bit_cnt counts decisions within the current state only.
      if (state_n != state) bit_cnt <= '0;
      else if (decide)      bit_cnt <= bit_cnt + 1'b1;

      if (ctr == HALF_M1) s_a <= rxs;
      if (ctr == HALF)    s_b <= rxs;

      if (state == S_DATA && decide) shreg <= {maj, shreg[DATA_BITS-1:1]};

      if (state == S_IDLE)             par_l <= 1'b0;
      else if (state == S_PAR && decide) par_l <= (^shreg) ^ maj ^ ODD;

      if (state == S_IDLE)                       frm_l <= 1'b0;
      else if (state == S_STOP && decide && !maj) frm_l <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit) begin
      data       <= shreg;
      parity_err <= par_l;
      frame_err  <= frm_l | ~maj;
      valid      <= 1'b1;
      if (valid && !ready)     overrun <= 1'b1;
      else if (valid && ready) overrun <= 1'b0;
    end else if (valid && ready) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end

endmodule
